// File: rtl/read_addr_sequencer.sv
// read_addr_sequencer
//   Read-side pointer for the 15-entry WriteReg bank. It walks a one-hot read
//   select in the same order as the write ring. It also counts how many entries
//   are written but not yet read, and hands them to the convolution datapath
//   over a valid/ready handshake. Reads are grouped into frames of FRAME_LEN
//   entries, and each frame begins with a start pulse.
//
//   Entry order: entry 0 is rd_sel[DEPTH-1]. The select walks down toward
//   bit 0 and then wraps back to bit DEPTH-1.
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset (shared with the write ring)
//   wr_en      write-ring advance strobe
//   start      single-cycle pulse, begins a frame when idle
//   out_ready  downstream accepts the current entry
//   rd_sel     one-hot read select into the bank
//   out_valid  entry under rd_sel is available
//   out_last   current entry is the last of the frame
//   level      written-but-unread entries, 0..DEPTH
//   busy       frame in progress (not idle)
//   done       one-cycle pulse after the last transfer of a frame
//   err        sticky overflow flag
//
// Build option
//   RSEQ_OVF_DETECT_EN: when defined, a write into a full bank counts as an
//   overflow. The oldest entry is dropped and err latches until reset. When
//   undefined, that write is ignored and err is tied to 0.

module read_addr_sequencer #(
    parameter int DEPTH     = 15,
    parameter int FRAME_LEN = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic             start,
    input  logic             out_ready,
    output logic [DEPTH-1:0] rd_sel,
    output logic             out_valid,
    output logic             out_last,
    output logic [3:0]       level,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [DEPTH-1:0] SEL_RST  = {1'b1, {(DEPTH-1){1'b0}}};
    localparam logic [3:0]       LVL_FULL = 4'(DEPTH);
    localparam logic [7:0]       CNT_LAST = 8'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     state;
    logic [7:0] rd_cnt;
    logic       xfer;
    logic       sel_adv;
    logic       full;

    // The outputs decode registered state only, so they are valid with zero
    // latency and do not depend combinationally on out_ready.
    assign out_valid = (state == S_RUN) && (level != 4'd0);
    assign out_last  = out_valid && (rd_cnt == CNT_LAST);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign xfer      = out_valid & out_ready;
    assign full      = (level == LVL_FULL);

`ifdef RSEQ_OVF_DETECT_EN
    logic ovf;
    logic err_q;

    // The writer overwrites the oldest entry, so the read pointer skips past it.
    assign ovf     = wr_en & ~xfer & full;
    assign sel_adv = xfer | ovf;
    assign err     = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_q <= 1'b0;
        else if (ovf)
            err_q <= 1'b1;
    end
`else
    assign sel_adv = xfer;
    assign err     = 1'b0;
`endif

    // Read pointer: move one entry down the bank and wrap from bit 0 to the top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rd_sel <= SEL_RST;
        else if (sel_adv)
            rd_sel <= {rd_sel[0], rd_sel[DEPTH-1:1]};
    end

    // Occupancy. A simultaneous write and read cancel out, even when full.
    // A write into a full bank leaves the count at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            level <= 4'd0;
        else if (wr_en && !xfer && !full)
            level <= level + 4'd1;
        else if (!wr_en && xfer)
            level <= level - 4'd1;
    end

    // Frame sequencer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            rd_cnt <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state  <= S_RUN;
                        rd_cnt <= 8'd0;
                    end
                end
                S_RUN: begin
                    if (xfer) begin
                        rd_cnt <= rd_cnt + 8'd1;
                        if (out_last)
                            state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    rd_cnt <= 8'd0;
                end
                default: begin
                    state  <= S_IDLE;
                    rd_cnt <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_read_addr_sequencer.sv
// Bench for read_addr_sequencer.
// Every cycle is checked against a reference model. The model keeps the read
// position as an integer index and the occupancy as a plain count.
// A table of hand-derived vectors covers the basic single-frame case, and
// short sequences cover wrap, stall, overflow and mid-frame reset.
// Randomized traffic runs last.

module tb_read_addr_sequencer;

    localparam int DEPTH = 15;
    localparam int FL    = 9;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wr_en;
    logic              start;
    logic              out_ready;
    logic [DEPTH-1:0]  rd_sel;
    logic              out_valid;
    logic              out_last;
    logic [3:0]        level;
    logic              busy;
    logic              done;
    logic              err;

    always #5 clk = ~clk;

    read_addr_sequencer #(.DEPTH(DEPTH), .FRAME_LEN(FL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .start     (start),
        .out_ready (out_ready),
        .rd_sel    (rd_sel),
        .out_valid (out_valid),
        .out_last  (out_last),
        .level     (level),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: head index, entry count, phase (0 idle, 1 run, 2 done).
    int m_idx, m_lvl, m_st, m_cnt;
    bit m_err;

`ifdef RSEQ_OVF_DETECT_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] obs();
        return {rd_sel, out_valid, out_last, level, busy, done, err};
    endfunction

    function automatic logic [23:0] model_obs();
        logic [DEPTH-1:0] one;
        logic [DEPTH-1:0] sel;
        bit v;
        one = 1;
        sel = one << (DEPTH - 1 - m_idx);
        v   = (m_st == 1) && (m_lvl > 0);
        return {sel, v, v && (m_cnt == FL - 1), 4'(m_lvl), m_st != 0, m_st == 2, m_err};
    endfunction

    task automatic model_reset();
        m_idx = 0; m_lvl = 0; m_st = 0; m_cnt = 0; m_err = 0;
    endtask

    task automatic model_step(input bit w, input bit s, input bit r);
        bit v, xf;
        v  = (m_st == 1) && (m_lvl > 0);
        xf = v && r;
        if (xf) m_idx = (m_idx + 1) % DEPTH;
        if (w && !xf) begin
            if (m_lvl < DEPTH) m_lvl++;
            else if (OVF_EN) begin
                m_idx = (m_idx + 1) % DEPTH;
                m_err = 1;
            end
        end else if (!w && xf) begin
            m_lvl--;
        end
        case (m_st)
            0: if (s) begin m_st = 1; m_cnt = 0; end
            1: if (xf) begin
                   if (m_cnt == FL - 1) m_st = 2;
                   m_cnt++;
               end
            default: begin m_st = 0; m_cnt = 0; end
        endcase
    endtask

    // Apply one cycle of inputs. Outputs are checked before the edge, and the
    // model then advances to match.
    task automatic cyc(input bit w, input bit s, input bit r);
        @(negedge clk);
        wr_en = w; start = s; out_ready = r;
        #1;
        chk("cycle", 32'(obs()), 32'(model_obs()));
        model_step(w, s, r);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; wr_en = 1'b0; start = 1'b0; out_ready = 1'b0;
        model_reset();
        #1;
        chk("reset", 32'(obs()), {8'h0, 15'h4000, 9'h0});
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit               w, s, r;
        logic [DEPTH-1:0] sel;
        bit               v, l;
        logic [3:0]       lvl;
        bit               b, d;
    } vec_t;

    vec_t tbl[21];

    initial begin
        int nread, nlast, nstart;
        bit s;
        logic [DEPTH-1:0] base;

        rst_n = 1'b0; wr_en = 1'b0; start = 1'b0; out_ready = 1'b0;
        model_reset();

        // Single frame: nine writes, start, then nine back-to-back reads.
        base = 15'h4000;
        for (int i = 0; i < 9; i++)
            tbl[i] = '{w:1, s:0, r:0, sel:base, v:0, l:0, lvl:4'(i), b:0, d:0};
        tbl[9] = '{w:0, s:1, r:0, sel:base, v:0, l:0, lvl:4'd9, b:0, d:0};
        for (int k = 0; k < 9; k++)
            tbl[10+k] = '{w:0, s:0, r:1, sel:base >> k, v:1, l:(k == 8),
                          lvl:4'(9 - k), b:1, d:0};
        tbl[19] = '{w:0, s:0, r:0, sel:15'h0020, v:0, l:0, lvl:4'd0, b:1, d:1};
        tbl[20] = '{w:0, s:0, r:0, sel:15'h0020, v:0, l:0, lvl:4'd0, b:0, d:0};

        do_reset();
        chk("reset_err", 32'(err), 32'd0);
        for (int i = 0; i < 21; i++) begin
            cyc(tbl[i].w, tbl[i].s, tbl[i].r);
            chk("tbl_sel", 32'(rd_sel), 32'(tbl[i].sel));
            chk("tbl_flags", {24'h0, out_valid, out_last, level, busy, done},
                {24'h0, tbl[i].v, tbl[i].l, tbl[i].lvl, tbl[i].b, tbl[i].d});
        end

        // Two frames with wr_en held high: check the wrap and the frame-2 last.
        do_reset();
        nread = 0; nlast = 0; nstart = 0;
        for (int c = 0; c < 100 && !(nstart == 2 && m_st == 0); c++) begin
            s = (m_st == 0) && (nstart < 2);
            if (s) nstart++;
            cyc(1'b1, s, 1'b1);
            if (out_valid) begin
                nread++;
                if (nread == 15) chk("wrap_sel15", 32'(rd_sel), 32'h0001);
                if (nread == 16) chk("wrap_sel16", 32'(rd_sel), 32'h4000);
                if (out_last) begin
                    nlast++;
                    chk("last_pos", nread, 9 * nlast);
                end
            end
        end
        chk("frames_done", nlast, 2);

        // Stall: valid holds and the select stays put; write+read keeps level.
        do_reset();
        repeat (3) cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0, 1'b0);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_sel", 32'(rd_sel), 32'h4000);
        end
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("wr_rd_level", 32'(level), 32'd3);
        chk("wr_rd_sel", 32'(rd_sel), 32'h2000);

        // Sixteen writes with no reads.
        do_reset();
        repeat (16) cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("ovf_level", 32'(level), 32'd15);
        chk("ovf_sel", 32'(rd_sel), OVF_EN ? 32'h2000 : 32'h4000);
        chk("ovf_err", 32'(err), OVF_EN ? 32'd1 : 32'd0);

        // Reset after the fourth transfer of a frame.
        do_reset();
        repeat (9) cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        repeat (4) cyc(1'b0, 1'b0, 1'b1);
        chk("mid_sel", 32'(rd_sel), 32'h0800);
        do_reset();
        repeat (9) cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("restart_valid", 32'(out_valid), 32'd1);
        chk("restart_sel", 32'(rd_sel), 32'h4000);

        // Randomized traffic with occasional resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0)
                do_reset();
            else
                cyc($urandom_range(0, 9) < 6, $urandom_range(0, 9) == 0,
                    $urandom_range(0, 9) < 7);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
